// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the twiddle multiplier and the
// two-requester arbiter that shares it.
//   FFT_WM_LATENCY : cycles from fft_wm sampling x/carry to carry_out
//   FFT_WM_W_SKEW  : cycles w trails x at the fft_wm inputs
//   arb_state_e    : arbiter grant state
package fft_pkg;
  localparam int FFT_WM_LATENCY = 4;
  localparam int FFT_WM_W_SKEW  = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/fft_wm_arb_if.sv
// fft_wm_arb_if: requester handshakes plus the shared result bus.
//   slave  : arbiter side (takes rK_valid/x/w, drives rK_ready, z_*, busy)
//   master : requester/owner side
interface fft_wm_arb_if #(
  parameter int WIDTH         = 24,
  parameter int TWIDDLE_WIDTH = 18,
  parameter int N             = 1024
);
  localparam int CW = $clog2(N);

  logic                            r0_valid, r0_ready;
  logic                            r1_valid, r1_ready;
  logic signed [WIDTH-1:0]         r0_x_re, r0_x_im, r1_x_re, r1_x_im;
  logic signed [TWIDDLE_WIDTH-1:0] r0_w_re, r0_w_im, r1_w_re, r1_w_im;
  logic signed [WIDTH-1:0]         z_re, z_im;
  logic [1:0]                      z_valid;
  logic [CW-1:0]                   z_ctr;
  logic                            busy;

  modport slave (
    input  r0_valid, r0_x_re, r0_x_im, r0_w_re, r0_w_im,
    input  r1_valid, r1_x_re, r1_x_im, r1_w_re, r1_w_im,
    output r0_ready, r1_ready, z_re, z_im, z_valid, z_ctr, busy
  );

  modport master (
    output r0_valid, r0_x_re, r0_x_im, r0_w_re, r0_w_im,
    output r1_valid, r1_x_re, r1_x_im, r1_w_re, r1_w_im,
    input  r0_ready, r1_ready, z_re, z_im, z_valid, z_ctr, busy
  );
endinterface

// File: rtl/fft_wm_arb_wm.sv
// fft_wm: pipelined complex twiddle multiplier z = x * w.
//   w is a signed Q1.(TWIDDLE_WIDTH-1) twiddle; the product is scaled back by
//   2^(TWIDDLE_WIDTH-1) with convergent (round-half-even) rounding and
//   wrapped to WIDTH bits.
// Ports:
//   clk, srst_n          clock, synchronous active-low reset (clears carries)
//   i_x_re/i_x_im        sample, sampled at edge S together with i_carry/i_ctr
//   i_w_re/i_w_im        twiddle, sampled at edge S+1
//   o_z_re/o_z_im/o_ctr  product and its index, valid with o_carry after S+3
//   o_inflight           any carry anywhere in the pipeline
module fft_wm
  import fft_pkg::*;
#(
  parameter int WIDTH         = 24,
  parameter int TWIDDLE_WIDTH = 18,
  parameter int CW            = 10
) (
  input  logic                            clk,
  input  logic                            srst_n,
  input  logic                            i_carry,
  input  logic [CW-1:0]                   i_ctr,
  input  logic signed [WIDTH-1:0]         i_x_re,
  input  logic signed [WIDTH-1:0]         i_x_im,
  input  logic signed [TWIDDLE_WIDTH-1:0] i_w_re,
  input  logic signed [TWIDDLE_WIDTH-1:0] i_w_im,
  output logic signed [WIDTH-1:0]         o_z_re,
  output logic signed [WIDTH-1:0]         o_z_im,
  output logic                            o_carry,
  output logic [CW-1:0]                   o_ctr,
  output logic                            o_inflight
);
  localparam int L  = FFT_WM_LATENCY;
  localparam int PW = WIDTH + TWIDDLE_WIDTH;
  localparam int SW = PW + 1;
  localparam int F  = TWIDDLE_WIDTH - 1;

  logic [L-1:0]                    r_vld_pipe;
  logic [L-1:0][CW-1:0]            r_ctr_pipe;
  logic signed [WIDTH-1:0]         r_x1_re, r_x1_im, r_x2_re, r_x2_im;
  logic signed [TWIDDLE_WIDTH-1:0] r_w2_re, r_w2_im;
  logic signed [PW-1:0]            r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [WIDTH-1:0]         r_z_re, r_z_im;
  logic signed [SW-1:0]            w_sum_re, w_sum_im;

  // Round half to even: bump the floor when the dropped fraction exceeds one
  // half, or equals one half and the floor is odd.
  function automatic logic [WIDTH-1:0] conv_rnd(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] fl;
    logic                 up;
    fl = s >>> F;
    up = s[F-1] & ((|s[F-2:0]) | fl[0]);
    return WIDTH'(fl + SW'(up));
  endfunction

  assign w_sum_re = SW'(r_p_rr) - SW'(r_p_ii);
  assign w_sum_im = SW'(r_p_ri) + SW'(r_p_ir);

  always_ff @(posedge clk) begin
    if (!srst_n) r_vld_pipe <= '0;
    else         r_vld_pipe <= {r_vld_pipe[L-2:0], i_carry};
  end

  // Stage S: x; stage S+1: x again plus the late-arriving w; S+2: partial
  // products; S+3: combine and round.
  always_ff @(posedge clk) begin
    r_ctr_pipe <= {r_ctr_pipe[L-2:0], i_ctr};
    r_x1_re    <= i_x_re;
    r_x1_im    <= i_x_im;
    r_x2_re    <= r_x1_re;
    r_x2_im    <= r_x1_im;
    r_w2_re    <= i_w_re;
    r_w2_im    <= i_w_im;
    r_p_rr     <= PW'(r_x2_re) * PW'(r_w2_re);
    r_p_ii     <= PW'(r_x2_im) * PW'(r_w2_im);
    r_p_ri     <= PW'(r_x2_re) * PW'(r_w2_im);
    r_p_ir     <= PW'(r_x2_im) * PW'(r_w2_re);
    r_z_re     <= conv_rnd(w_sum_re);
    r_z_im     <= conv_rnd(w_sum_im);
  end

  assign o_z_re     = r_z_re;
  assign o_z_im     = r_z_im;
  assign o_carry    = r_vld_pipe[L-1];
  assign o_ctr      = r_ctr_pipe[L-1];
  assign o_inflight = |r_vld_pipe;
endmodule

// File: rtl/fft_wm_arb.sv
// fft_wm_arb: frame-granular round-robin arbiter sharing one fft_wm between
// two requesters. A grant lasts a full frame of N transfers; at least one
// IDLE cycle separates frames. Results return on the shared z bus with a
// one-hot owner in z_valid and the in-frame index in z_ctr.
// Ports:
//   clk, srst_n  clock, synchronous active-low reset
//   bus          fft_wm_arb_if.slave (requester handshakes, x/w, z, busy)
module fft_wm_arb
  import fft_pkg::*;
#(
  parameter int WIDTH         = 24,
  parameter int TWIDDLE_WIDTH = 18,
  parameter int N             = 1024
) (
  input  logic         clk,
  input  logic         srst_n,
  fft_wm_arb_if.slave  bus
);
  localparam int CW = $clog2(N);
  localparam int L  = FFT_WM_LATENCY;
  localparam int SK = FFT_WM_W_SKEW;

  arb_state_e r_state, w_state_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_rr_ptr, w_rr_nxt;
  logic [CW-1:0] r_frame_ctr, w_ctr_nxt;
  logic [1:0] w_valid, w_ready;
  logic       w_xfer;

  logic signed [WIDTH-1:0]                 w_x_re, w_x_im, r_x_re, r_x_im;
  logic signed [TWIDDLE_WIDTH-1:0]         w_w_re, w_w_im;
  logic [SK:0][TWIDDLE_WIDTH-1:0]          r_w_re_pipe, r_w_im_pipe;
  logic                                    r_carry, r_tag;
  logic [CW-1:0]                           r_ctr;
  logic [L-1:0]                            r_tag_pipe;
  logic                                    w_carry_o, w_inflight;
  logic [CW-1:0]                           w_ctr_o;

  assign w_valid = {bus.r1_valid, bus.r0_valid};

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_ctr_nxt   = r_frame_ctr;
    w_ready     = 2'b00;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_valid) begin
          w_state_nxt = GRANT;
          // A lone requester wins outright; rr_ptr only breaks ties.
          w_owner_nxt = (&w_valid) ? r_rr_ptr : w_valid[1];
        end
      end
      GRANT: begin
        w_ready[r_owner] = 1'b1;
        w_xfer           = w_valid[r_owner];
        if (w_xfer) begin
          w_ctr_nxt = r_frame_ctr + 1'b1;  // N is a power of two: wraps to 0
          if (r_frame_ctr == CW'(N - 1)) begin
            w_state_nxt = IDLE;
            w_rr_nxt    = ~r_owner;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_frame_ctr <= '0;
      r_carry     <= 1'b0;
      r_tag       <= 1'b0;
      r_tag_pipe  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_frame_ctr <= w_ctr_nxt;
      r_carry     <= w_xfer;
      r_tag       <= r_owner;
      r_tag_pipe  <= {r_tag_pipe[L-2:0], r_tag};
    end
  end

  assign w_x_re = r_owner ? bus.r1_x_re : bus.r0_x_re;
  assign w_x_im = r_owner ? bus.r1_x_im : bus.r0_x_im;
  assign w_w_re = r_owner ? bus.r1_w_re : bus.r0_w_re;
  assign w_w_im = r_owner ? bus.r1_w_im : bus.r0_w_im;

  // Data is don't-care without r_carry, so the issue registers run freely.
  // w gets SK extra stages because fft_wm samples it SK cycles after x.
  always_ff @(posedge clk) begin
    r_x_re      <= w_x_re;
    r_x_im      <= w_x_im;
    r_ctr       <= r_frame_ctr;
    r_w_re_pipe <= {r_w_re_pipe[SK-1:0], w_w_re};
    r_w_im_pipe <= {r_w_im_pipe[SK-1:0], w_w_im};
  end

  fft_wm #(
    .WIDTH        (WIDTH),
    .TWIDDLE_WIDTH(TWIDDLE_WIDTH),
    .CW           (CW)
  ) u_wm (
    .clk       (clk),
    .srst_n    (srst_n),
    .i_carry   (r_carry),
    .i_ctr     (r_ctr),
    .i_x_re    (r_x_re),
    .i_x_im    (r_x_im),
    .i_w_re    (r_w_re_pipe[SK]),
    .i_w_im    (r_w_im_pipe[SK]),
    .o_z_re    (bus.z_re),
    .o_z_im    (bus.z_im),
    .o_carry   (w_carry_o),
    .o_ctr     (w_ctr_o),
    .o_inflight(w_inflight)
  );

  assign bus.r0_ready = w_ready[0];
  assign bus.r1_ready = w_ready[1];
  assign bus.z_ctr    = w_ctr_o;
  assign bus.z_valid  = w_carry_o ? (r_tag_pipe[L-1] ? 2'b10 : 2'b01) : 2'b00;
  assign bus.busy     = (r_state != IDLE) | r_carry | w_inflight;
endmodule

// File: doc/fft_wm_arb.md
# fft_wm_arb

Frame-granular round-robin arbiter that shares one `fft_wm` twiddle multiplier between two requesters, e.g. two FFT stages or two channels time-multiplexed onto one DSP-backed complex multiplier.
- Accepts samples from each requester over valid/ready.
- Drives the multiplier with correct x/w skew.
- Returns each product to its owner, tagged with the original sample index.
- The grant is held for a whole frame of N samples so frame ordering inside the multiplier is never interleaved.

## Interface
Parameters:
- WIDTH, 24, sample component width (signed)
- TWIDDLE_WIDTH, 18, twiddle component width (signed)
- N, 1024, samples per frame; power of two, ≥ 2

Ports:
- clk  in  1  clock
- srst_n  in  1  synchronous reset, active-low
- rK_valid  in  1  requester K (K=0,1) sample valid
- rK_ready  out  1  requester K may transfer this cycle
- rK_x_re, rK_x_im  in  WIDTH  requester K sample
- rK_w_re, rK_w_im  in  TWIDDLE_WIDTH  twiddle for the same sample (same cycle as x)
- z_re, z_im  out  WIDTH  product (shared bus)
- z_valid  out  2  one-hot owner of z this cycle; 00 = none
- z_ctr  out  $clog2(N)  sample index within owner's frame
- busy  out  1  grant held or results in flight

## Operation
- Transfer on requester K = rK_valid & rK_ready at a rising edge.
- FSM states:
  - IDLE: no grant; both ready = 0.
    - If any valid, grant the requester that `rr_ptr` selects. `rr_ptr` points to the requester that did not hold the last grant; reset value 0.
    - If only one requester is valid, grant it regardless of `rr_ptr`.
    - Go to GRANT.
  - GRANT: rK_ready = 1 for the owner only; the other requester's ready = 0.
    - `frame_ctr` (width $clog2(N)) increments on each transfer; invalid cycles are gaps (no multiplier issue, no counter change).
    - On the transfer with frame_ctr = N-1: ready drops the next cycle, `frame_ctr` wraps to 0, `rr_ptr` points to the other requester, and the FSM goes to IDLE.
- No back-to-back grants: IDLE always lasts ≥ 1 cycle between frames. Accepted throughput overhead: 1 cycle per N.
- Issue to `fft_wm`:
  - x, carry_in (= transfer) and ctr_i (= frame_ctr) are registered at the transfer edge T, so the multiplier samples them at T+1.
  - w passes through one extra register, so the multiplier samples it at T+2. `fft_wm` consumes w one cycle after x.
- Routing:
  - A 1-bit owner tag enters a shift register alongside carry_in; its length matches the `fft_wm` pipeline.
  - z_valid[tag] = carry_out; z_re, z_im and z_ctr come directly from the multiplier outputs.
- Arithmetic (convergent rounding, width handling) is entirely inside `fft_wm`; the arbiter does not alter data.
- busy = (state ≠ IDLE) | any in-flight carry. Results cannot be back-pressured: owners must accept z every cycle.

## Timing
- Reset values:
  - rK_ready = 0, z_valid = 00, busy = 0
  - state = IDLE, rr_ptr = 0, frame_ctr = 0
  - carry/tag pipeline cleared
  - z_re, z_im and z_ctr are don't-care while z_valid = 00
- Grant latency: valid seen in IDLE at edge E → ready high after E (first possible transfer at E+1).
- Data latency: transfer at edge T → z_valid high after edge T+4. The gap pattern is preserved, one result per transfer.
- Simultaneous valid in IDLE: rr_ptr decides; the loser waits exactly one frame plus one IDLE cycle.
- Owner deasserts valid mid-frame: grant is kept indefinitely; no timeout.
- Reset mid-frame or with results in flight: all in-flight results are dropped and no z_valid appears after reset. Requesters restart frames at index 0.

## Structure
- Shared package `fft_pkg`: `FFT_WM_LATENCY` (=4), `FFT_WM_W_SKEW` (=1), and the arbiter state enum {IDLE, GRANT}.
- Sub-module: one `fft_wm` instance (the shared resource).
- The round-robin pointer and grant logic are small enough to stay inline.

## Test plan
- Single requester r0, N=8, valid continuous, x=(1000,0), w=(131071,0) → 8 results on z_valid=01, z_ctr 0..7, z_re≈1000, first result 4 cycles after the first transfer.
- Both valid from reset, N=8 → r0 frame fully served, IDLE 1 cycle, then r1 frame; z_valid never mixes owners within a frame.
- r1 alone for 3 frames, then r0 and r1 contend → r0 is granted first (rr_ptr points away from r1).
- Gaps: r0 valid pattern 1,0,0,1,… for N=8 → z_valid reproduces the gaps with 4-cycle offset, and z_ctr stays contiguous 0..7.
- Skew check: x=(0,1000), w=(0,131071) changing every sample → z equals the model product of same-index pairs (catches off-by-one w alignment).
- srst_n low for 1 cycle at sample 5 of a frame with 3 results in flight → z_valid=00 for all following cycles until new transfers, ready=0 after reset, frame_ctr restarts at 0.
